// File: rtl/awp_dispatch.sv
// awp_dispatch: CPU-side initiator for AWP floating-point jobs.
// It starts a job with efp/ldstate and holds puf while the job runs.
// Each sr_fp access request is served with one bus cycle, which ends in a got strobe.
// The job ends on ekc_fp, and puf then drops.
// Optional watchdog: define AWP_WATCHDOG_EN to abort jobs that never see ekc_fp.
module awp_dispatch #(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 11
) (
   input  logic clk_sys,
   input  logic rst_,
   input  logic fp_req,
   output logic fp_busy,
   output logic fp_done,
   output logic fp_alarm,
   output logic efp,
   output logic ldstate,
   output logic puf,
   input  logic ekc_fp,
   input  logic sr_fp,
   input  logic read_fp,
   output logic bus_req,
   output logic bus_we,
   input  logic bus_ack,
   input  logic bus_ok,
   output logic ok,
   output logic got
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_RUN,
      S_ACCESS,
      S_RELEASE,
      S_FINISH,
      S_ALARM
   } state_e;

   state_e state_q, state_d;
   logic   ekc_q, ekc_d;
   logic   we_q, we_d;
   logic   got_q, got_d;
   logic   ok_q, ok_d;

   // Elaboration guard: the watchdog counter must be able to represent TIMEOUT
   if (TIMEOUT < 1 || TIMEOUT >= (1 << CNT_W)) begin : g_cfg_check
      $error("awp_dispatch: CNT_W too narrow for TIMEOUT");
   end

`ifdef AWP_WATCHDOG_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expire;

   // Count the cycles spent in the running states; the counter restarts at every job start
   always_comb begin
      cnt_d = '0;
      case (state_q)
         S_RUN, S_ACCESS, S_RELEASE: cnt_d = cnt_q + CNT_W'(1);
         default:                    cnt_d = '0;
      endcase
   end

   assign expire = ((state_q == S_RUN) || (state_q == S_ACCESS) || (state_q == S_RELEASE))
                   && (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

   // State register and side flags; reset forces IDLE so every decoded output drops at once
   always_ff @(posedge clk_sys or negedge rst_) begin
      if (!rst_) begin
         state_q <= S_IDLE;
         ekc_q   <= 1'b0;
         we_q    <= 1'b0;
         got_q   <= 1'b0;
         ok_q    <= 1'b0;
`ifdef AWP_WATCHDOG_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ekc_q   <= ekc_d;
         we_q    <= we_d;
         got_q   <= got_d;
         ok_q    <= ok_d;
`ifdef AWP_WATCHDOG_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Next-state logic; a sticky ekc flag defers job end until an access has completed
   always_comb begin
      state_d = state_q;
      ekc_d   = ekc_q;
      we_d    = we_q;
      got_d   = 1'b0;
      ok_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            ekc_d = 1'b0;
            if (fp_req) state_d = S_START;
         end
         S_START: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            ekc_d = ekc_q | ekc_fp;
            if (ekc_q || ekc_fp) begin
               state_d = S_FINISH;
            end else if (sr_fp) begin
               we_d    = ~read_fp;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            ekc_d = ekc_q | ekc_fp;
            if (bus_ack) begin
               got_d   = 1'b1;
               ok_d    = bus_ok;
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            ekc_d = ekc_q | ekc_fp;
            if (!sr_fp) state_d = S_RUN;
         end
         S_FINISH, S_ALARM: begin
            ekc_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            ekc_d   = 1'b0;
            state_d = S_IDLE;
         end
      endcase
`ifdef AWP_WATCHDOG_EN
      if (expire) begin
         state_d = S_ALARM;
         got_d   = 1'b0;
         ok_d    = 1'b0;
      end
`endif
   end

   // Output decode: every output comes from state or a flop, never from an input
   always_comb begin
      fp_busy  = (state_q != S_IDLE);
      fp_done  = (state_q == S_FINISH);
`ifdef AWP_WATCHDOG_EN
      fp_alarm = (state_q == S_ALARM);
`else
      fp_alarm = 1'b0;
`endif
      efp      = (state_q == S_START);
      ldstate  = (state_q == S_START);
      puf      = (state_q == S_START) || (state_q == S_RUN) ||
                 (state_q == S_ACCESS) || (state_q == S_RELEASE);
      bus_req  = (state_q == S_ACCESS);
      bus_we   = (state_q == S_ACCESS) && we_q;
      got      = got_q;
      ok       = ok_q;
   end

endmodule

// File: tb/tb_awp_dispatch.sv
// Testbench for awp_dispatch: directed protocol scenarios followed by randomized traffic,
// all checked every cycle against a job-level reference model.
module tb_awp_dispatch;

   localparam int TB_TIMEOUT = 16;
`ifdef AWP_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic clk_sys = 1'b0;
   logic rst_    = 1'b0;
   logic fp_req  = 1'b0;
   logic ekc_fp  = 1'b0;
   logic sr_fp   = 1'b0;
   logic read_fp = 1'b0;
   logic bus_ack = 1'b0;
   logic bus_ok  = 1'b0;
   logic fp_busy, fp_done, fp_alarm, efp, ldstate, puf, bus_req, bus_we, ok, got;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: describes a job as "running", "serving an access", "waiting for the request to drop"
   bit jobOn, startCyc, accessOpen, holdOff, endSeen, finishCyc, alarmCyc;
   bit weLatched, gotPulse, okVal;
   int runCycles;

   // Event tallies used by the directed scenarios
   int efpCount, doneCount, gotCount, busReqRises, alarmCount;
   bit prevBusReq;

   // Random stimulus helpers
   int dropCnt;

   awp_dispatch #(.TIMEOUT(TB_TIMEOUT), .CNT_W(5)) dut (
      .clk_sys (clk_sys),
      .rst_    (rst_),
      .fp_req  (fp_req),
      .fp_busy (fp_busy),
      .fp_done (fp_done),
      .fp_alarm(fp_alarm),
      .efp     (efp),
      .ldstate (ldstate),
      .puf     (puf),
      .ekc_fp  (ekc_fp),
      .sr_fp   (sr_fp),
      .read_fp (read_fp),
      .bus_req (bus_req),
      .bus_we  (bus_we),
      .bus_ack (bus_ack),
      .bus_ok  (bus_ok),
      .ok      (ok),
      .got     (got)
   );

   // Free-running system clock
   always #5 clk_sys = ~clk_sys;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Return the model to its power-on condition
   task automatic modelReset();
      jobOn = 0; startCyc = 0; accessOpen = 0; holdOff = 0; endSeen = 0;
      finishCyc = 0; alarmCyc = 0; weLatched = 0; gotPulse = 0; okVal = 0;
      runCycles = 0;
   endtask

   // Advance the model by one clock using the inputs present at the edge
   task automatic modelStep();
      bit nGot, nOk;
      nGot = 0;
      nOk  = 0;
      if (finishCyc || alarmCyc) begin
         finishCyc = 0;
         alarmCyc  = 0;
         endSeen   = 0;
      end else if (!jobOn) begin
         endSeen = 0;
         if (fp_req) begin
            jobOn     = 1;
            startCyc  = 1;
            runCycles = 0;
         end
      end else if (startCyc) begin
         startCyc = 0;
      end else begin
         if (ekc_fp) endSeen = 1;
         if (WD && (runCycles + 1 == TB_TIMEOUT)) begin
            jobOn      = 0;
            accessOpen = 0;
            holdOff    = 0;
            alarmCyc   = 1;
         end else begin
            runCycles++;
            if (accessOpen) begin
               if (bus_ack) begin
                  accessOpen = 0;
                  holdOff    = 1;
                  nGot       = 1;
                  nOk        = bus_ok;
               end
            end else if (holdOff) begin
               if (!sr_fp) holdOff = 0;
            end else if (endSeen) begin
               jobOn     = 0;
               finishCyc = 1;
            end else if (sr_fp) begin
               accessOpen = 1;
               weLatched  = !read_fp;
            end
         end
      end
      gotPulse = nGot;
      okVal    = nOk;
   endtask

   // Compare every DUT output against what the model says the current cycle should show
   task automatic compareAll();
      checkOutput("fp_busy",  fp_busy,  jobOn || finishCyc || alarmCyc);
      checkOutput("fp_done",  fp_done,  finishCyc);
      checkOutput("fp_alarm", fp_alarm, alarmCyc);
      checkOutput("efp",      efp,      startCyc);
      checkOutput("ldstate",  ldstate,  startCyc);
      checkOutput("puf",      puf,      jobOn);
      checkOutput("bus_req",  bus_req,  accessOpen);
      checkOutput("bus_we",   bus_we,   accessOpen && weLatched);
      checkOutput("got",      got,      gotPulse);
      checkOutput("ok",       ok,       gotPulse && okVal);
   endtask

   // One clock: step the model on the rising edge, check and tally on the falling edge
   task automatic cycle();
      @(posedge clk_sys);
      modelStep();
      @(negedge clk_sys);
      compareAll();
      if (efp) efpCount++;
      if (fp_done) doneCount++;
      if (got) gotCount++;
      if (fp_alarm) alarmCount++;
      if (bus_req && !prevBusReq) busReqRises++;
      prevBusReq = bus_req;
   endtask

   task automatic clearTallies();
      efpCount = 0; doneCount = 0; gotCount = 0; busReqRises = 0; alarmCount = 0;
   endtask

   task automatic idleInputs();
      fp_req = 0; ekc_fp = 0; sr_fp = 0; read_fp = 0; bus_ack = 0; bus_ok = 0;
   endtask

   // Launch a job; returns at the falling edge of the first RUN cycle
   task automatic startJob();
      fp_req = 1;
      cycle();
      fp_req = 0;
      cycle();
   endtask

   // End a running job with a one-cycle ekc and let it return to IDLE
   task automatic endJob();
      ekc_fp = 1;
      cycle();
      ekc_fp = 0;
      cycle();
   endtask

   // Randomized AWP/memory behaviour that still respects the sr_fp level protocol
   task automatic applyStimulus();
      fp_req  = ($urandom_range(0, 3) == 0);
      ekc_fp  = ($urandom_range(0, 9) == 0);
      bus_ack = ($urandom_range(0, 2) == 0);
      bus_ok  = $urandom_range(0, 1) != 0;
      if (gotPulse) dropCnt = $urandom_range(0, 3);
      if (sr_fp) begin
         if (!jobOn) begin
            sr_fp   = 0;
            dropCnt = -1;
         end else if (dropCnt == 0) begin
            sr_fp   = 0;
            dropCnt = -1;
         end else if (dropCnt > 0) begin
            dropCnt--;
         end
      end else if ($urandom_range(0, 3) == 0) begin
         sr_fp   = 1;
         read_fp = $urandom_range(0, 1) != 0;
         dropCnt = -1;
      end
   endtask

   initial begin
      modelReset();
      clearTallies();
      prevBusReq = 0;
      dropCnt    = -1;

      // Outputs while reset is held
      #12;
      checkOutput("reset_busy",    fp_busy, 0);
      checkOutput("reset_puf",     puf,     0);
      checkOutput("reset_efp",     efp,     0);
      checkOutput("reset_bus_req", bus_req, 0);
      checkOutput("reset_got",     got,     0);
      @(negedge clk_sys);
      rst_ = 1;
      cycle();

      // Simple job: ekc three cycles after START
      clearTallies();
      fp_req = 1;
      cycle();
      checkOutput("simple_efp_in_start", efp, 1);
      fp_req = 0;
      cycle();
      cycle();
      ekc_fp = 1;
      cycle();
      checkOutput("simple_done", fp_done, 1);
      checkOutput("simple_puf_low", puf, 0);
      ekc_fp = 0;
      cycle();
      checkOutput("simple_busy_low", fp_busy, 0);
      checkOutput("simple_efp_pulses", efpCount, 1);
      checkOutput("simple_done_pulses", doneCount, 1);

      // Read access: ack after 4 cycles, sr_fp held 2 cycles past got
      startJob();
      clearTallies();
      sr_fp = 1; read_fp = 1;
      cycle();
      checkOutput("read_bus_we", bus_we, 0);
      repeat (3) cycle();
      bus_ack = 1; bus_ok = 1;
      cycle();
      checkOutput("read_got", got, 1);
      checkOutput("read_ok", ok, 1);
      bus_ack = 0; bus_ok = 0;
      repeat (2) cycle();
      sr_fp = 0;
      cycle();
      checkOutput("read_got_pulses", gotCount, 1);
      checkOutput("read_bus_req_cycles", busReqRises, 1);
      endJob();

      // Write access that fails
      startJob();
      clearTallies();
      sr_fp = 1; read_fp = 0;
      cycle();
      checkOutput("write_bus_we", bus_we, 1);
      cycle();
      bus_ack = 1; bus_ok = 0;
      cycle();
      checkOutput("write_got", got, 1);
      checkOutput("write_ok", ok, 0);
      bus_ack = 0; sr_fp = 0;
      cycle();
      checkOutput("write_back_to_run_puf", puf, 1);
      endJob();

      // ekc arrives mid-access and is honoured once the access is released
      startJob();
      clearTallies();
      sr_fp = 1; read_fp = 1;
      cycle();
      ekc_fp = 1;
      cycle();
      ekc_fp = 0;
      cycle();
      checkOutput("ekc_access_still_req", bus_req, 1);
      bus_ack = 1; bus_ok = 1;
      cycle();
      bus_ack = 0; sr_fp = 0;
      cycle();
      cycle();
      checkOutput("ekc_done", fp_done, 1);
      cycle();
      checkOutput("ekc_got_pulses", gotCount, 1);
      checkOutput("ekc_done_pulses", doneCount, 1);

`ifdef AWP_WATCHDOG_EN
      // Watchdog: no ekc, alarm after TIMEOUT running cycles
      startJob();
      clearTallies();
      repeat (TB_TIMEOUT) cycle();
      checkOutput("wd_alarm", fp_alarm, 1);
      checkOutput("wd_puf", puf, 0);
      cycle();
      checkOutput("wd_idle", fp_busy, 0);
      checkOutput("wd_no_done", doneCount, 0);
      checkOutput("wd_alarm_pulses", alarmCount, 1);
`endif

      // Async reset while an access is open
      startJob();
      sr_fp = 1; read_fp = 1;
      cycle();
      checkOutput("arst_in_access", bus_req, 1);
      #2;
      rst_ = 0;
      #1;
      checkOutput("arst_bus_req", bus_req, 0);
      checkOutput("arst_puf", puf, 0);
      checkOutput("arst_busy", fp_busy, 0);
      idleInputs();
      modelReset();
      @(negedge clk_sys);
      rst_ = 1;
      fp_req = 1;
      cycle();
      checkOutput("arst_restart_efp", efp, 1);
      fp_req = 0;
      cycle();
      endJob();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         applyStimulus();
         cycle();
      end
      idleInputs();
      repeat (TB_TIMEOUT + 4) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
